// File: rtl/rs_issue_arbiter.sv
// Round-robin issue pick of one ready RS entry for the ALU; define RS_PRIO_EN to favour req_prio entries.
// Latency: req to issue_valid is 1 cycle from IDLE, with back-to-back issue on fire.
// Backpressure: the selection is held stable until alu_ready; rdy=0 freezes all state.
module rs_issue_arbiter #(
    parameter int RS_SIZE = 16,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               flush,
    input  logic [RS_SIZE-1:0] req,
    input  logic [RS_SIZE-1:0] req_prio,
    input  logic               alu_ready,
    output logic               issue_valid,
    output logic [IDX_W-1:0]   issue_idx,
    output logic               issue_fire
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   idx_d;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   ptr_d;
    logic [RS_SIZE-1:0] fired_mask;
    logic [RS_SIZE-1:0] mask_d;

    logic [RS_SIZE-1:0] held_onehot;
    logic [RS_SIZE-1:0] elig;
    logic [RS_SIZE-1:0] cand;
    logic [IDX_W-1:0]   scan_ptr;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic [IDX_W:0]     pick;

    // First set bit of vec at or after ptr, wrapping; MSB of result is the found flag.
    function automatic logic [IDX_W:0] rr_pick(input logic [RS_SIZE-1:0] vec,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] probe;
        logic             found;
        logic [IDX_W-1:0] res;
        found = 1'b0;
        res   = ptr;
        for (int i = 0; i < RS_SIZE; i++) begin
            probe = ptr + IDX_W'(i);
            if (!found && vec[probe]) begin
                found = 1'b1;
                res   = probe;
            end
        end
        return {found, res};
    endfunction

    assign held_onehot = RS_SIZE'(1) << issue_idx;

    always_comb begin
        elig = req & ~fired_mask;
        if (state_q == HOLD) begin
            elig = elig & ~held_onehot;
        end
    end

`ifdef RS_PRIO_EN
    logic [RS_SIZE-1:0] elig_prio;
    assign elig_prio = elig & req_prio;
    assign cand      = (|elig_prio) ? elig_prio : elig;
`else
    logic unused_req_prio;
    assign unused_req_prio = ^req_prio;
    assign cand            = elig;
`endif

    // While holding, the only selection that matters is the back-to-back one after a fire.
    assign scan_ptr  = (state_q == HOLD) ? issue_idx + IDX_W'(1) : rr_ptr;
    assign pick      = rr_pick(cand, scan_ptr);
    assign sel_found = pick[IDX_W];
    assign sel_idx   = pick[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            issue_idx  <= '0;
            rr_ptr     <= '0;
            fired_mask <= '0;
        end else begin
            state_q    <= state_d;
            issue_idx  <= idx_d;
            rr_ptr     <= ptr_d;
            fired_mask <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = issue_idx;
        ptr_d   = rr_ptr;
        mask_d  = fired_mask;
        if (rdy) begin
            mask_d = '0;
            if (flush) begin
                state_d = IDLE;
                ptr_d   = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (sel_found) begin
                            state_d = HOLD;
                            idx_d   = sel_idx;
                        end
                    end
                    HOLD: begin
                        if (alu_ready) begin
                            ptr_d  = issue_idx + IDX_W'(1);
                            mask_d = held_onehot;
                            if (sel_found) begin
                                idx_d = sel_idx;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // A reset cycle never fires, even if a selection was still being held.
    always_comb begin
        issue_valid = (state_q == HOLD);
        issue_fire  = issue_valid & alu_ready & rdy & ~flush & rst;
    end

    a_fire_needs_valid: assert property (@(posedge clk) disable iff (!rst)
        issue_fire |-> issue_valid);
    a_frozen_no_fire: assert property (@(posedge clk) disable iff (!rst)
        !rdy |-> !issue_fire);
    a_mask_onehot0: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(fired_mask));

endmodule
